// File: rtl/rom_access_pkg.sv
// Shared types and constants for the SNES-side ROM/SRAM access sequencer.
// Holds the sequencer state encoding and the byte-lane select value.
package rom_access_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSrd,
        StSwr,
        StMrd,
        StMwr,
        StRecov
    } state_e;

    // ADDR[0] equal to this value selects the low byte lane (MEM_DIN[7:0], BLE_N).
    localparam logic LANE_LO = 1'b0;

endpackage

// File: rtl/rom_access_seq_if.sv
// Bus bundle between the address decoder / SNES / MCU side and the sequencer,
// including the external 16-bit memory pins.
interface rom_access_seq_if #(
    parameter int unsigned ADDR_W = 24
) ();
    logic              SNES_RD_N;
    logic              SNES_WR_N;
    logic [ADDR_W-1:0] ROM_ADDR;
    logic              ROM_HIT;
    logic              IS_WRITABLE;
    logic [7:0]        SNES_DIN;
    logic [7:0]        SNES_DOUT;
    logic              SNES_DVALID;
    logic              MCU_RRQ;
    logic              MCU_WRQ;
    logic [ADDR_W-1:0] MCU_ADDR;
    logic [7:0]        MCU_WDATA;
    logic [7:0]        MCU_RDATA;
    logic              MCU_RDY;
    logic [ADDR_W-2:0] MEM_ADDR;
    logic [15:0]       MEM_DOUT;
    logic [15:0]       MEM_DIN;
    logic              MEM_DOE;
    logic              MEM_CE_N;
    logic              MEM_OE_N;
    logic              MEM_WE_N;
    logic              MEM_BHE_N;
    logic              MEM_BLE_N;

    modport slave (
        input  SNES_RD_N, SNES_WR_N, ROM_ADDR, ROM_HIT, IS_WRITABLE, SNES_DIN,
        input  MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_WDATA, MEM_DIN,
        output SNES_DOUT, SNES_DVALID, MCU_RDATA, MCU_RDY,
        output MEM_ADDR, MEM_DOUT, MEM_DOE, MEM_CE_N, MEM_OE_N, MEM_WE_N, MEM_BHE_N, MEM_BLE_N
    );

    modport master (
        output SNES_RD_N, SNES_WR_N, ROM_ADDR, ROM_HIT, IS_WRITABLE, SNES_DIN,
        output MCU_RRQ, MCU_WRQ, MCU_ADDR, MCU_WDATA, MEM_DIN,
        input  SNES_DOUT, SNES_DVALID, MCU_RDATA, MCU_RDY,
        input  MEM_ADDR, MEM_DOUT, MEM_DOE, MEM_CE_N, MEM_OE_N, MEM_WE_N, MEM_BHE_N, MEM_BLE_N
    );
endinterface

// File: rtl/snes_strobe_sync.sv
// Two-flop synchronizer for an active-low SNES strobe with single-cycle edge pulses.
// Registers reset to 1 so an idle-high strobe produces no edge out of reset.
module snes_strobe_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_strobe_n,
    output logic o_rise,
    output logic o_fall,
    output logic o_busy
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_strobe_n;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;
    // An edge has reached the first flop but not yet produced its pulse.
    assign o_busy = r_meta ^ r_sync;
endmodule

// File: rtl/rom_access_seq.sv
// Performs timed SNES and MCU reads/writes on the external 16-bit memory.
// SNES accesses always win; MCU requests fill the gaps between SNES cycles.
module rom_access_seq
    import rom_access_pkg::*;
#(
    parameter int unsigned RD_CYCLES = 4,
    parameter int unsigned WR_CYCLES = 4,
    parameter int unsigned ADDR_W    = 24
) (
    input logic             CLK,
    input logic             RST_N,
    rom_access_seq_if.slave bus
);
    localparam int unsigned MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

    logic w_rd_rise, w_rd_fall, w_rd_busy;
    logic w_wr_rise, w_wr_fall, w_wr_busy;

    snes_strobe_sync u_rd_sync (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_strobe_n(bus.SNES_RD_N),
        .o_rise    (w_rd_rise),
        .o_fall    (w_rd_fall),
        .o_busy    (w_rd_busy)
    );

    snes_strobe_sync u_wr_sync (
        .i_clk     (CLK),
        .i_rst_n   (RST_N),
        .i_strobe_n(bus.SNES_WR_N),
        .o_rise    (w_wr_rise),
        .o_fall    (w_wr_fall),
        .o_busy    (w_wr_busy)
    );

    state_e            r_state, w_state_d;
    logic [CNT_W-1:0]  r_cnt, w_cnt_d;
    logic [ADDR_W-2:0] r_mem_addr;
    logic              r_lane;
    logic [15:0]       r_mem_dout;
    logic              r_ce_n, r_oe_n, r_we_n, r_bhe_n, r_ble_n, r_doe;
    logic [7:0]        r_snes_dout, r_mcu_rdata;
    logic              r_snes_dvalid, r_mcu_rdy;
    logic              r_sp_valid, r_sp_wr;
    logic [ADDR_W-1:0] r_sp_addr;
    logic [7:0]        r_sp_data;
    logic              r_mp_valid, r_mp_wr;
    logic [7:0]        r_mp_data;

    logic              w_rd_ev, w_wr_ev, w_snes_ev, w_snes_hold, w_mcu_acc;
    logic              w_launch, w_l_snes, w_l_wr, w_lane_d, w_last;
    logic              w_access, w_rd_acc, w_wr_acc;
    logic [ADDR_W-1:0] w_l_addr;
    logic [7:0]        w_l_data, w_rd_byte;

    assign w_rd_ev   = w_rd_fall & bus.ROM_HIT;
    assign w_wr_ev   = w_wr_rise & bus.ROM_HIT & bus.IS_WRITABLE;
    assign w_snes_ev = w_rd_ev | w_wr_ev;
    // Hold MCU launches while an SNES edge is still crossing the synchronizer, so an
    // SNES strobe and an MCU pulse arriving together are served SNES first.
    assign w_snes_hold = w_rd_busy | w_wr_busy | w_wr_fall;
    assign w_mcu_acc   = r_mcu_rdy & (bus.MCU_RRQ | bus.MCU_WRQ);
    assign w_last      = (r_cnt == '0);
    assign w_rd_byte   = (r_lane == LANE_LO) ? bus.MEM_DIN[7:0] : bus.MEM_DIN[15:8];

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_launch  = 1'b0;
        w_l_snes  = 1'b0;
        w_l_wr    = 1'b0;
        w_l_addr  = bus.ROM_ADDR;
        w_l_data  = bus.SNES_DIN;
        unique case (r_state)
            StIdle: begin
                if (w_snes_ev) begin
                    w_launch = 1'b1;
                    w_l_snes = 1'b1;
                    w_l_wr   = ~w_rd_ev;
                end else if (r_sp_valid) begin
                    w_launch = 1'b1;
                    w_l_snes = 1'b1;
                    w_l_wr   = r_sp_wr;
                    w_l_addr = r_sp_addr;
                    w_l_data = r_sp_data;
                end else if (r_mp_valid && !w_snes_hold) begin
                    w_launch = 1'b1;
                    w_l_wr   = r_mp_wr;
                    w_l_addr = bus.MCU_ADDR;
                    w_l_data = r_mp_data;
                end
                if (w_launch) begin
                    w_state_d = w_l_snes ? (w_l_wr ? StSwr : StSrd) : (w_l_wr ? StMwr : StMrd);
                    w_cnt_d   = w_l_wr ? WR_LOAD : RD_LOAD;
                end
            end
            StSrd, StSwr, StMrd, StMwr: begin
                if (w_last) w_state_d = StRecov;
                else        w_cnt_d   = r_cnt - 1'b1;
            end
            StRecov: w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    assign w_rd_acc = (w_state_d == StSrd) || (w_state_d == StMrd);
    assign w_wr_acc = (w_state_d == StSwr) || (w_state_d == StMwr);
    assign w_access = w_rd_acc | w_wr_acc;
    assign w_lane_d = w_launch ? w_l_addr[0] : r_lane;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= StIdle;
            r_cnt         <= '0;
            r_mem_addr    <= '0;
            r_lane        <= LANE_LO;
            r_mem_dout    <= '0;
            r_ce_n        <= 1'b1;
            r_oe_n        <= 1'b1;
            r_we_n        <= 1'b1;
            r_bhe_n       <= 1'b1;
            r_ble_n       <= 1'b1;
            r_doe         <= 1'b0;
            r_snes_dout   <= '0;
            r_snes_dvalid <= 1'b0;
            r_mcu_rdata   <= '0;
            r_mcu_rdy     <= 1'b1;
            r_sp_valid    <= 1'b0;
            r_sp_wr       <= 1'b0;
            r_sp_addr     <= '0;
            r_sp_data     <= '0;
            r_mp_valid    <= 1'b0;
            r_mp_wr       <= 1'b0;
            r_mp_data     <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_lane  <= w_lane_d;
            r_ce_n  <= ~w_access;
            r_oe_n  <= ~w_rd_acc;
            r_we_n  <= ~w_wr_acc;
            r_doe   <= w_wr_acc;
            r_ble_n <= ~(w_access && (w_lane_d == LANE_LO));
            r_bhe_n <= ~(w_access && (w_lane_d != LANE_LO));
            if (w_launch) begin
                r_mem_addr <= w_l_addr[ADDR_W-1:1];
                if (w_l_wr) r_mem_dout <= {w_l_data, w_l_data};
            end

            if (r_state == StSrd && w_last) begin
                r_snes_dout   <= w_rd_byte;
                r_snes_dvalid <= 1'b1;
            end else if (w_rd_rise) begin
                r_snes_dvalid <= 1'b0;
            end

            if (r_state == StMrd && w_last) r_mcu_rdata <= w_rd_byte;
            if ((r_state == StMrd || r_state == StMwr) && w_last) r_mcu_rdy <= 1'b1;
            else if (w_mcu_acc)                                     r_mcu_rdy <= 1'b0;

            if (w_mcu_acc) begin
                r_mp_valid <= 1'b1;
                r_mp_wr    <= bus.MCU_WRQ & ~bus.MCU_RRQ;
                r_mp_data  <= bus.MCU_WDATA;
            end else if (w_launch && !w_l_snes) begin
                r_mp_valid <= 1'b0;
            end

            // Single slot: a newer SNES event simply overwrites an unserviced one.
            if (w_snes_ev && r_state != StIdle) begin
                r_sp_valid <= 1'b1;
                r_sp_wr    <= ~w_rd_ev;
                r_sp_addr  <= bus.ROM_ADDR;
                r_sp_data  <= bus.SNES_DIN;
            end else if (w_launch && w_l_snes) begin
                r_sp_valid <= 1'b0;
            end
        end
    end

    assign bus.MEM_ADDR    = r_mem_addr;
    assign bus.MEM_DOUT    = r_mem_dout;
    assign bus.MEM_DOE     = r_doe;
    assign bus.MEM_CE_N    = r_ce_n;
    assign bus.MEM_OE_N    = r_oe_n;
    assign bus.MEM_WE_N    = r_we_n;
    assign bus.MEM_BHE_N   = r_bhe_n;
    assign bus.MEM_BLE_N   = r_ble_n;
    assign bus.SNES_DOUT   = r_snes_dout;
    assign bus.SNES_DVALID = r_snes_dvalid;
    assign bus.MCU_RDATA   = r_mcu_rdata;
    assign bus.MCU_RDY     = r_mcu_rdy;
endmodule

// File: tb/tb_rom_access_seq.sv
// Scoreboard bench for rom_access_seq: expected memory cycles and read results are
// queued as stimulus is driven and checked by a monitor as the DUT produces them.
module tb_rom_access_seq;
    localparam int unsigned AW = 24;

    typedef struct packed {logic [22:0] addr; logic lane;} rd_exp_t;
    typedef struct packed {logic [22:0] addr; logic [15:0] dout; logic lane;} wr_exp_t;
    typedef struct packed {logic is_rd; logic [7:0] data;} mcu_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rom_access_seq_if #(.ADDR_W(AW)) bus ();

    rom_access_seq #(
        .RD_CYCLES(4),
        .WR_CYCLES(4),
        .ADDR_W   (AW)
    ) dut (
        .CLK  (clk),
        .RST_N(rst_n),
        .bus  (bus)
    );

    function automatic logic [15:0] mem_model(input logic [22:0] a);
        if (a == 23'h091A2B) return 16'hA55A;
        return {a[7:0] ^ 8'h3C, a[7:0] ^ 8'hC3};
    endfunction

    assign bus.MEM_DIN = mem_model(bus.MEM_ADDR);

    rd_exp_t  rd_q[$];
    wr_exp_t  wr_q[$];
    mcu_exp_t mcu_q[$];
    logic [7:0] snes_q[$];

    int n_checks = 0;
    int n_fails  = 0;
    int n_wr     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples on the falling clock edge, away from DUT updates.
    logic p_oe_n = 1'b1, p_we_n = 1'b1, p_dvalid = 1'b0, p_rdy = 1'b1;
    int   oe_len = 0, we_len = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            p_oe_n   <= 1'b1;
            p_we_n   <= 1'b1;
            p_dvalid <= 1'b0;
            p_rdy    <= 1'b1;
            oe_len   <= 0;
            we_len   <= 0;
        end else begin
            if (p_oe_n && !bus.MEM_OE_N) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", 32'(bus.MEM_ADDR), 32'hFFFF_FFFF);
                end else begin
                    rd_exp_t e;
                    e = rd_q.pop_front();
                    check("rd_addr", 32'(bus.MEM_ADDR), 32'(e.addr));
                    check("rd_bhe_n", 32'(bus.MEM_BHE_N), 32'(!e.lane));
                    check("rd_ble_n", 32'(bus.MEM_BLE_N), 32'(e.lane));
                    check("rd_ce_we_doe", 32'({bus.MEM_CE_N, bus.MEM_WE_N, bus.MEM_DOE}), 32'b010);
                end
            end
            if (p_we_n && !bus.MEM_WE_N) begin
                n_wr <= n_wr + 1;
                if (wr_q.size() == 0) begin
                    check("unexpected_write", 32'(bus.MEM_ADDR), 32'hFFFF_FFFF);
                end else begin
                    wr_exp_t e;
                    e = wr_q.pop_front();
                    check("wr_addr", 32'(bus.MEM_ADDR), 32'(e.addr));
                    check("wr_dout", 32'(bus.MEM_DOUT), 32'(e.dout));
                    check("wr_bhe_n", 32'(bus.MEM_BHE_N), 32'(!e.lane));
                    check("wr_ble_n", 32'(bus.MEM_BLE_N), 32'(e.lane));
                    check("wr_ce_oe_doe", 32'({bus.MEM_CE_N, bus.MEM_OE_N, bus.MEM_DOE}), 32'b011);
                end
            end
            if (!p_oe_n && bus.MEM_OE_N) check("oe_low_cycles", 32'(oe_len), 32'd4);
            if (!p_we_n && bus.MEM_WE_N) check("we_low_cycles", 32'(we_len), 32'd4);
            oe_len <= bus.MEM_OE_N ? 0 : oe_len + 1;
            we_len <= bus.MEM_WE_N ? 0 : we_len + 1;

            if (!p_dvalid && bus.SNES_DVALID) begin
                if (snes_q.size() == 0) check("unexpected_dvalid", 32'(bus.SNES_DOUT), 32'hFFFF_FFFF);
                else check("snes_dout", 32'(bus.SNES_DOUT), 32'(snes_q.pop_front()));
            end
            if (!p_rdy && bus.MCU_RDY) begin
                check("rdy_in_recov", 32'({bus.MEM_CE_N, bus.MEM_DOE}), 32'b10);
                if (mcu_q.size() == 0) begin
                    check("unexpected_mcu_done", 32'(bus.MCU_RDATA), 32'hFFFF_FFFF);
                end else begin
                    mcu_exp_t m;
                    m = mcu_q.pop_front();
                    if (m.is_rd) check("mcu_rdata", 32'(bus.MCU_RDATA), 32'(m.data));
                end
            end
            p_oe_n   <= bus.MEM_OE_N;
            p_we_n   <= bus.MEM_WE_N;
            p_dvalid <= bus.SNES_DVALID;
            p_rdy    <= bus.MCU_RDY;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int cyc;
    int base_wr;

    initial begin
        bus.SNES_RD_N   = 1'b1;
        bus.SNES_WR_N   = 1'b1;
        bus.ROM_ADDR    = '0;
        bus.ROM_HIT     = 1'b0;
        bus.IS_WRITABLE = 1'b0;
        bus.SNES_DIN    = '0;
        bus.MCU_RRQ     = 1'b0;
        bus.MCU_WRQ     = 1'b0;
        bus.MCU_ADDR    = '0;
        bus.MCU_WDATA   = '0;

        step(3);
        check("rst_strobes_n", 32'({bus.MEM_CE_N, bus.MEM_OE_N, bus.MEM_WE_N, bus.MEM_BHE_N,
                                    bus.MEM_BLE_N}), 32'b11111);
        check("rst_doe", 32'(bus.MEM_DOE), 32'd0);
        check("rst_mem_addr", 32'(bus.MEM_ADDR), 32'd0);
        check("rst_mem_dout", 32'(bus.MEM_DOUT), 32'd0);
        check("rst_snes_dout", 32'(bus.SNES_DOUT), 32'd0);
        check("rst_dvalid", 32'(bus.SNES_DVALID), 32'd0);
        check("rst_mcu_rdata", 32'(bus.MCU_RDATA), 32'd0);
        check("rst_mcu_rdy", 32'(bus.MCU_RDY), 32'd1);
        rst_n = 1'b1;
        step(3);

        // SNES read at an odd address: high lane, data on DVALID, cleared by RD rising.
        bus.ROM_ADDR = 24'h123457;
        bus.ROM_HIT = 1'b1;
        bus.SNES_RD_N = 1'b0;
        rd_q.push_back('{23'h091A2B, 1'b1});
        snes_q.push_back(8'hA5);
        cyc = 0;
        while (bus.SNES_DVALID !== 1'b1 && cyc < 40) begin
            step(1);
            cyc++;
        end
        check("t1_dvalid_seen", 32'(bus.SNES_DVALID), 32'd1);
        check("t1_latency_range", 32'(cyc >= 7 && cyc <= 8), 32'd1);
        step(3);
        check("t1_dvalid_held", 32'(bus.SNES_DVALID), 32'd1);
        bus.SNES_RD_N = 1'b1;
        step(4);
        check("t1_dvalid_cleared", 32'(bus.SNES_DVALID), 32'd0);
        check("t1_dout_held", 32'(bus.SNES_DOUT), 32'hA5);
        bus.ROM_HIT = 1'b0;
        step(2);

        // SNES write to a writable even address, then the same to a non-writable one.
        base_wr = n_wr;
        bus.ROM_ADDR = 24'hE00010;
        bus.SNES_DIN = 8'h3C;
        bus.ROM_HIT = 1'b1;
        bus.IS_WRITABLE = 1'b1;
        bus.SNES_WR_N = 1'b0;
        wr_q.push_back('{23'h700008, 16'h3C3C, 1'b0});
        step(4);
        bus.SNES_WR_N = 1'b1;
        step(12);
        check("t2_one_write", 32'(n_wr - base_wr), 32'd1);
        base_wr = n_wr;
        bus.IS_WRITABLE = 1'b0;
        bus.SNES_DIN = 8'h55;
        bus.SNES_WR_N = 1'b0;
        step(4);
        bus.SNES_WR_N = 1'b1;
        step(12);
        check("t2_no_write_ro", 32'(n_wr - base_wr), 32'd0);
        bus.ROM_HIT = 1'b0;
        step(2);

        // MCU read pulse together with an SNES read fall: SNES first, then MCU.
        bus.ROM_ADDR = 24'h123457;
        bus.ROM_HIT = 1'b1;
        bus.SNES_RD_N = 1'b0;
        bus.MCU_ADDR = 24'h000001;
        bus.MCU_RRQ = 1'b1;
        rd_q.push_back('{23'h091A2B, 1'b1});
        rd_q.push_back('{23'h000000, 1'b1});
        snes_q.push_back(8'hA5);
        mcu_q.push_back('{1'b1, 8'h3C});
        step(1);
        bus.MCU_RRQ = 1'b0;
        check("t3_rdy_dropped", 32'(bus.MCU_RDY), 32'd0);
        cyc = 0;
        while (bus.SNES_DVALID !== 1'b1 && cyc < 40) begin
            step(1);
            cyc++;
        end
        check("t3_dvalid_seen", 32'(bus.SNES_DVALID), 32'd1);
        check("t3_rdy_still_low", 32'(bus.MCU_RDY), 32'd0);
        cyc = 0;
        while (bus.MCU_RDY !== 1'b1 && cyc < 40) begin
            step(1);
            cyc++;
        end
        check("t3_rdy_seen", 32'(bus.MCU_RDY), 32'd1);
        check("t3_mcu_rdata_hi", 32'(bus.MCU_RDATA), 32'h3C);
        bus.SNES_RD_N = 1'b1;
        bus.ROM_HIT = 1'b0;
        step(5);

        // SNES read arriving during an MCU write is served right after RECOV.
        bus.MCU_ADDR = 24'h000100;
        bus.MCU_WDATA = 8'h77;
        bus.MCU_WRQ = 1'b1;
        wr_q.push_back('{23'h000080, 16'h7777, 1'b0});
        mcu_q.push_back('{1'b0, 8'h00});
        step(1);
        bus.MCU_WRQ = 1'b0;
        cyc = 0;
        while (bus.MEM_WE_N !== 1'b0 && cyc < 20) begin
            step(1);
            cyc++;
        end
        check("t4_we_seen", 32'(bus.MEM_WE_N), 32'd0);
        bus.ROM_ADDR = 24'h000203;
        bus.ROM_HIT = 1'b1;
        bus.SNES_RD_N = 1'b0;
        rd_q.push_back('{23'h000101, 1'b1});
        snes_q.push_back(8'h3D);
        cyc = 0;
        while (bus.SNES_DVALID !== 1'b1 && cyc < 40) begin
            step(1);
            cyc++;
        end
        check("t4_dvalid_seen", 32'(bus.SNES_DVALID), 32'd1);
        check("t4_latency_bound", 32'(cyc >= 7 && cyc <= 14), 32'd1);
        bus.SNES_RD_N = 1'b1;
        bus.ROM_HIT = 1'b0;
        step(5);

        // A second MCU write pulse while busy must be ignored.
        base_wr = n_wr;
        bus.MCU_ADDR = 24'h000040;
        bus.MCU_WDATA = 8'h5A;
        bus.MCU_WRQ = 1'b1;
        wr_q.push_back('{23'h000020, 16'h5A5A, 1'b0});
        mcu_q.push_back('{1'b0, 8'h00});
        step(1);
        bus.MCU_WDATA = 8'h99;
        step(1);
        bus.MCU_WRQ = 1'b0;
        step(1);
        bus.MCU_WRQ = 1'b1;
        step(1);
        bus.MCU_WRQ = 1'b0;
        cyc = 0;
        while (bus.MCU_RDY !== 1'b1 && cyc < 40) begin
            step(1);
            cyc++;
        end
        check("t5_rdy_seen", 32'(bus.MCU_RDY), 32'd1);
        step(10);
        check("t5_one_write", 32'(n_wr - base_wr), 32'd1);

        // Reset during an SNES read: strobes release immediately, nothing resumes.
        bus.ROM_ADDR = 24'h000010;
        bus.ROM_HIT = 1'b1;
        bus.SNES_RD_N = 1'b0;
        rd_q.push_back('{23'h000008, 1'b0});
        cyc = 0;
        while (bus.MEM_OE_N !== 1'b0 && cyc < 20) begin
            step(1);
            cyc++;
        end
        check("t6_oe_seen", 32'(bus.MEM_OE_N), 32'd0);
        step(1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_async_release", 32'({bus.MEM_CE_N, bus.MEM_OE_N, bus.MEM_BLE_N}), 32'b111);
        bus.SNES_RD_N = 1'b1;
        bus.ROM_HIT = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(20);
        check("t6_rdy_after", 32'(bus.MCU_RDY), 32'd1);
        check("t6_dvalid_after", 32'(bus.SNES_DVALID), 32'd0);
        check("t6_idle_strobes", 32'({bus.MEM_CE_N, bus.MEM_OE_N, bus.MEM_WE_N}), 32'b111);

        check("rd_q_drained", 32'(rd_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("snes_q_drained", 32'(snes_q.size()), 32'd0);
        check("mcu_q_drained", 32'(mcu_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/rom_access_seq.md
Name: rom_access_seq

Overview:
Responder side of the SNES address decode: it takes the decoded ROM_ADDR/ROM_HIT/IS_WRITABLE for each SNES bus cycle and performs the timed read or write on the external 16-bit cartridge memory (SRAM0). It also services MCU memory requests in the gaps between SNES cycles, and SNES always has priority. It sits between the address decoder outputs, the SNES data bus drivers and the memory pins.

Parameters:
RD_CYCLES, 4, CLK cycles that OE_n is held low for a read; data is sampled on the last one.
WR_CYCLES, 4, CLK cycles that WE_n is held low for a write.
ADDR_W, 24, width of the byte address from the decoder and the MCU.

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
SNES_RD_N  in  1  SNES read strobe, asynchronous to CLK
SNES_WR_N  in  1  SNES write strobe, asynchronous to CLK
ROM_ADDR  in  ADDR_W  decoded memory byte address
ROM_HIT  in  1  cycle targets memory
IS_WRITABLE  in  1  cycle may write memory
SNES_DIN  in  8  SNES write data
SNES_DOUT  out  8  last SNES read byte
SNES_DVALID  out  1  SNES_DOUT is valid for the current read
MCU_RRQ  in  1  one-cycle MCU read request pulse
MCU_WRQ  in  1  one-cycle MCU write request pulse
MCU_ADDR  in  ADDR_W  MCU byte address, held from the request until MCU_RDY
MCU_WDATA  in  8  MCU write byte
MCU_RDATA  out  8  MCU read byte
MCU_RDY  out  1  1 = idle or MCU operation complete
MEM_ADDR  out  ADDR_W-1  word address
MEM_DOUT  out  16  write data, byte replicated on both lanes
MEM_DIN  in  16  read data
MEM_DOE  out  1  memory data bus output enable
MEM_CE_N, MEM_OE_N, MEM_WE_N, MEM_BHE_N, MEM_BLE_N  out  1 each  memory strobes

Behaviour:
- Reset values: all MEM_*_N=1, MEM_DOE=0, MEM_ADDR=0, MEM_DOUT=0, SNES_DOUT=0, SNES_DVALID=0, MCU_RDATA=0, MCU_RDY=1. FSM=IDLE. Pending flags=0.
- Reset mid-operation: strobes deassert asynchronously. Any in-flight or pending access is dropped and no completion is signalled.
- SNES strobes pass through a 2-FF synchronizer plus edge detect; a detected edge lags the pin by 2-3 CLK.
- Read event: RD falling edge with ROM_HIT=1. Write event: WR rising edge with ROM_HIT=1 and IS_WRITABLE=1. Address and data are captured in the cycle the event is detected. All other edges are ignored.
- SNES event while the FSM is not IDLE: latched into one pending slot. A second event before service overwrites the slot.
- MCU pulse when MCU_RDY=1: latched as pending and MCU_RDY drops the next cycle. A pulse when MCU_RDY=0 is ignored. RRQ and WRQ in the same cycle: treated as a read.
- FSM states: IDLE, SRD, SWR, MRD, MWR, RECOV.
  - From IDLE, pending SNES takes priority over pending MCU.
  - SRD/MRD: CE_N=OE_N=0, byte enable = ADDR[0] (0 selects the low lane), counter = RD_CYCLES-1.
  - On counter==0, capture the selected byte of MEM_DIN, then go to RECOV.
  - SWR/MWR: MEM_DOE=1, CE_N=WE_N=0 for WR_CYCLES, then RECOV.
  - RECOV: all strobes high, MEM_DOE=0 for exactly 1 cycle, then IDLE. The next pending access is evaluated in the following cycle.
- Latency from event to data: read = RD_CYCLES+1 CLK. Simultaneous SNES and MCU events: SNES first, MCU afterwards.
- SRD completion: SNES_DOUT updated and SNES_DVALID=1. SNES_DVALID clears on the synchronized RD rising edge. SNES_DOUT holds its value.
- MRD completion: MCU_RDATA updated and MCU_RDY=1 in the RECOV cycle. MWR completion: MCU_RDY=1 in the RECOV cycle.
- Counter width is clog2(max(RD_CYCLES,WR_CYCLES)). RD_CYCLES/WR_CYCLES=1 is legal (single-cycle strobe).
- MEM_ADDR=ADDR[ADDR_W-1:1], with no wrap logic; the upper bits come straight from the decoder.

Decomposition:
- Package rom_access_pkg: FSM state enum, and a localparam for the lane select (LANE_LO=0).
- One sub-module, snes_strobe_sync: 2-FF synchronizer with rise/fall pulses, instantiated for RD_N and WR_N.

Test Plan:
- SNES read, ROM_ADDR=0x123457, MEM_DIN=0xA55A, ROM_HIT=1 -> MEM_ADDR=0x091A2B, BHE_N=0, OE_N low 4 CLK, SNES_DOUT=0xA5, DVALID=1 until RD rises.
- SNES write 0x3C, IS_WRITABLE=1, ROM_ADDR=0xE00010 -> WE_N low 4 CLK, BLE_N=0, MEM_DOUT=0x3C3C. Repeat with IS_WRITABLE=0 -> no WE_N pulse.
- MCU read pulse at 0x000001 in the same cycle as an SNES RD fall -> SRD completes first, then MRD. MCU_RDY stays 0 until MRD RECOV, and MCU_RDATA equals the high byte.
- SNES RD fall during MWR -> pending slot is serviced right after RECOV, and the SNES read completes within WR_CYCLES+RD_CYCLES+3 CLK of detection.
- MCU_WRQ pulsed while MCU_RDY=0 -> ignored, exactly one write is seen on the memory.
- RST_N asserted mid-SRD (counter=2) -> OE_N/CE_N=1 immediately. After release: IDLE, MCU_RDY=1, no stale access.
